// File: rtl/dvr_rng_pkg.sv
// Shared types and reference sequences for the RNG stream scheduler.
package dvr_rng_pkg;

  // Scheduler FSM: IDLE arbitrates among pending requests, STREAM feeds one burst.
  typedef enum logic {S_IDLE, S_STREAM} sched_state_t;

  localparam int SERVED_W = 32;

  // Deterministic 64-bit reference word stream (index -> word).
  function automatic logic [63:0] seq64(input int unsigned idx);
    logic [63:0] x;
    x = {32'h0, idx} * 64'h9E37_79B9_7F4A_7C15 + 64'h0123_4567_89AB_CDEF;
    x = x ^ (x >> 29);
    x = x * 64'hBF58_476D_1CE4_E5B9;
    x = x ^ (x >> 31);
    return x;
  endfunction

  // 32-bit reference words are the low halves of the 64-bit stream.
  function automatic logic [31:0] seq32(input int unsigned idx);
    logic [63:0] w;
    w = seq64(idx);
    return w[31:0];
  endfunction

endpackage

// File: rtl/dvr_rng_rr_pick.sv
// Combinational round-robin picker: first set request after last_i, wrapping.
module dvr_rng_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   last_i,
  output logic               found_o,
  output logic [IDX_W-1:0]   idx_o
);

  // Scan last+1 .. last+NUM_REQ (mod NUM_REQ); the first hit wins.
  always_comb begin
    int cand;
    logic [IDX_W-1:0] cand_idx;
    found_o  = 1'b0;
    idx_o    = '0;
    cand     = 0;
    cand_idx = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = int'(last_i) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      cand_idx = IDX_W'(cand);
      if (!found_o && req_i[cand_idx]) begin
        found_o = 1'b1;
        idx_o   = cand_idx;
      end
    end
  end

endmodule

// File: rtl/dvr_rng_sched.sv
// Round-robin scheduler sharing one RNG word stream among NUM_REQ burst consumers.
// Handshake: a word moves when rng_valid_in and the granted consumer's
// data_ready_in are both high at a clock edge; valid never waits on ready,
// and ready from non-granted consumers is ignored.
module dvr_rng_sched
  import dvr_rng_pkg::*;
#(
  parameter int WIDTH    = 64,
  parameter int NUM_REQ  = 4,
  parameter int CNT_BITS = 8
) (
  input  logic                          sysClk_in,
  input  logic                          sysRst_n_in,
  input  logic [WIDTH-1:0]              rng_data_in,
  input  logic                          rng_valid_in,
  output logic                          rng_ready_out,
  input  logic [NUM_REQ-1:0]            req_valid_in,
  input  logic [NUM_REQ*CNT_BITS-1:0]   req_count_in,
  output logic [NUM_REQ-1:0]            req_ready_out,
  output logic [WIDTH-1:0]              data_out,
  output logic [NUM_REQ-1:0]            data_valid_out,
  input  logic [NUM_REQ-1:0]            data_ready_in,
  output logic [$clog2(NUM_REQ)-1:0]    grant_out,
  output logic                          busy_out,
  output logic [31:0]                   served_out
);

  localparam int IDX_W = $clog2(NUM_REQ);

  sched_state_t          state_q, state_d;
  logic [IDX_W-1:0]      grant_q, grant_d;
  logic [CNT_BITS-1:0]   remaining_q, remaining_d;
  logic [CNT_BITS-1:0]   pending_q [NUM_REQ];
  logic [CNT_BITS-1:0]   pending_d [NUM_REQ];
  logic [SERVED_W-1:0]   served_q, served_d;

  logic [NUM_REQ-1:0]    pend_nz;
  logic                  pick_found;
  logic [IDX_W-1:0]      pick_idx;
  logic                  busy;
  logic                  xfer;

  dvr_rng_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req_i   (pend_nz),
    .last_i  (grant_q),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  // Per-consumer request status and the streaming datapath.
  always_comb begin
    busy           = (state_q == S_STREAM);
    xfer           = busy && rng_valid_in && data_ready_in[grant_q];
    data_out       = rng_data_in;
    data_valid_out = '0;
    rng_ready_out  = 1'b0;
    if (busy) begin
      data_valid_out[grant_q] = rng_valid_in;
      rng_ready_out           = data_ready_in[grant_q];
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      pend_nz[i]       = (pending_q[i] != '0);
      req_ready_out[i] = !pend_nz[i] && !(busy && (grant_q == IDX_W'(i)));
    end
    busy_out   = busy;
    grant_out  = grant_q;
    served_out = served_q;
  end

  // Next state: request capture, arbitration in IDLE, word counting in STREAM.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    remaining_d = remaining_q;
    served_d    = served_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      pending_d[i] = pending_q[i];
      // Zero-length requests are accepted but leave nothing pending.
      if (req_valid_in[i] && req_ready_out[i] &&
          (req_count_in[i*CNT_BITS +: CNT_BITS] != '0)) begin
        pending_d[i] = req_count_in[i*CNT_BITS +: CNT_BITS];
      end
    end
    case (state_q)
      S_IDLE: begin
        // The picker only sees registered pending counts, so a request
        // captured this cycle competes in the next arbitration.
        if (pick_found) begin
          grant_d             = pick_idx;
          remaining_d         = pending_q[pick_idx];
          pending_d[pick_idx] = '0;
          state_d             = S_STREAM;
        end
      end
      S_STREAM: begin
        if (xfer) begin
          remaining_d = remaining_q - CNT_BITS'(1);
          served_d    = served_q + SERVED_W'(1);
          if (remaining_q == CNT_BITS'(1)) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset discards any burst in flight and all pending requests.
  always_ff @(posedge sysClk_in or negedge sysRst_n_in) begin
    if (!sysRst_n_in) begin
      state_q     <= S_IDLE;
      grant_q     <= IDX_W'(NUM_REQ - 1);
      remaining_q <= '0;
      served_q    <= '0;
      for (int i = 0; i < NUM_REQ; i++) pending_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      remaining_q <= remaining_d;
      served_q    <= served_d;
      for (int i = 0; i < NUM_REQ; i++) pending_q[i] <= pending_d[i];
    end
  end

endmodule

// File: tb/tb_dvr_rng_sched.sv
// Directed bench for dvr_rng_sched: RNG replays seq64 with valid/ready.
module tb_dvr_rng_sched;
  import dvr_rng_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [63:0] rng_data_in;
  logic        rng_valid_in = 1'b1;
  logic        rng_ready_out;
  logic [3:0]  req_valid_in = '0;
  logic [31:0] req_count_in = '0;
  logic [3:0]  req_ready_out;
  logic [63:0] data_out;
  logic [3:0]  data_valid_out;
  logic [3:0]  data_ready_in = 4'hF;
  logic [1:0]  grant_out;
  logic        busy_out;
  logic [31:0] served_out;

  int          tests_run = 0;
  int          fails = 0;
  int          exp_served = 0;
  int unsigned rng_idx = 0;
  logic        rng_clr = 1'b0;
  int          cyc = 0;
  int          onehot_err = 0;
  int          got_who[$];
  logic [63:0] got_data[$];
  int          got_cyc[$];

  dvr_rng_sched #(.WIDTH(64), .NUM_REQ(4), .CNT_BITS(8)) dut (
    .sysClk_in      (clk),
    .sysRst_n_in    (rst_n),
    .rng_data_in    (rng_data_in),
    .rng_valid_in   (rng_valid_in),
    .rng_ready_out  (rng_ready_out),
    .req_valid_in   (req_valid_in),
    .req_count_in   (req_count_in),
    .req_ready_out  (req_ready_out),
    .data_out       (data_out),
    .data_valid_out (data_valid_out),
    .data_ready_in  (data_ready_in),
    .grant_out      (grant_out),
    .busy_out       (busy_out),
    .served_out     (served_out)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // RNG model: presents seq64[rng_idx], advances on a completed handshake.
  assign rng_data_in = seq64(rng_idx);
  always @(posedge clk) begin
    if (rng_clr) rng_idx <= 0;
    else if (rng_valid_in && rng_ready_out) rng_idx <= rng_idx + 1;
  end

  // Consumer monitor: logs every word a consumer will take at the next edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if ($countones(data_valid_out) > 1) onehot_err <= onehot_err + 1;
      for (int i = 0; i < 4; i++) begin
        if (data_valid_out[i] && data_ready_in[i]) begin
          got_who.push_back(i);
          got_data.push_back(data_out);
          got_cyc.push_back(cyc);
        end
      end
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_req();
    req_valid_in = '0;
    req_count_in = '0;
  endtask

  task automatic post(input int i, input int cnt);
    req_valid_in[i] = 1'b1;
    req_count_in[i*8 +: 8] = 8'(cnt);
  endtask

  task automatic do_reset();
    clear_req();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    exp_served = 0;
  endtask

  task automatic rng_restart();
    rng_clr = 1'b1;
    tick();
    rng_clr = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < budget; n++) begin
      if (!busy_out && req_ready_out == 4'hF) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  // Scoreboard pass over a logged range: expected consumer ids and seq64 words.
  task automatic count_bad(input int base, input int n, input int exp_who[$], output int bad);
    bad = 0;
    for (int k = 0; k < n; k++) begin
      if (base + k >= got_who.size()) bad++;
      else if (got_who[base+k] != exp_who[k] || got_data[base+k] !== seq64(k)) bad++;
    end
  endtask

  task automatic test_reset();
    clear_req();
    #2 rst_n = 1'b0;
    #1;
    tests_run++; if (busy_out !== 1'b0) begin fails++; $display("FAIL reset_busy: got %0b want 0", busy_out); end
    tests_run++; if (served_out !== 32'd0) begin fails++; $display("FAIL reset_served: got %0d want 0", served_out); end
    tests_run++; if (grant_out !== 2'd3) begin fails++; $display("FAIL reset_grant: got %0d want 3", grant_out); end
    tests_run++; if (data_valid_out !== 4'h0) begin fails++; $display("FAIL reset_valid: got %0h want 0", data_valid_out); end
    tests_run++; if (rng_ready_out !== 1'b0) begin fails++; $display("FAIL reset_rng_ready: got %0b want 0", rng_ready_out); end
    tests_run++; if (req_ready_out !== 4'hF) begin fails++; $display("FAIL reset_req_ready: got %0h want f", req_ready_out); end
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    tests_run++; if (busy_out !== 1'b0) begin fails++; $display("FAIL post_reset_busy: got %0b want 0", busy_out); end
    tests_run++; if (rng_ready_out !== 1'b0) begin fails++; $display("FAIL idle_rng_ready: got %0b want 0", rng_ready_out); end
    exp_served = 0;
  endtask

  task automatic test_single();
    int base, bad;
    int exp_who[$];
    rng_restart();
    base = got_who.size();
    post(0, 5);
    tick();
    clear_req();
    tests_run++; if (req_ready_out !== 4'b1110) begin fails++; $display("FAIL single_pending: got %0h want e", req_ready_out); end
    tick();
    tests_run++; if (busy_out !== 1'b1) begin fails++; $display("FAIL single_busy: got %0b want 1", busy_out); end
    tests_run++; if (grant_out !== 2'd0) begin fails++; $display("FAIL single_grant: got %0d want 0", grant_out); end
    tests_run++; if (data_valid_out !== 4'b0001) begin fails++; $display("FAIL single_valid: got %0h want 1", data_valid_out); end
    tests_run++; if (rng_ready_out !== 1'b1) begin fails++; $display("FAIL single_rng_ready: got %0b want 1", rng_ready_out); end
    tests_run++; if (data_out !== seq64(0)) begin fails++; $display("FAIL single_data0: got %0h want %0h", data_out, seq64(0)); end
    repeat (4) tick();
    tests_run++; if (busy_out !== 1'b1) begin fails++; $display("FAIL single_busy_w4: got %0b want 1", busy_out); end
    tick();
    tests_run++; if (busy_out !== 1'b0) begin fails++; $display("FAIL single_busy_drop: got %0b want 0", busy_out); end
    repeat (5) exp_who.push_back(0);
    count_bad(base, 5, exp_who, bad);
    tests_run++; if (bad != 0) begin fails++; $display("FAIL single_words: got %0d bad want 0", bad); end
    tests_run++; if (got_who.size() - base != 5) begin fails++; $display("FAIL single_count: got %0d want 5", got_who.size() - base); end
    if (got_who.size() - base >= 5) begin
      tests_run++; if (got_cyc[base+4] - got_cyc[base] != 4) begin fails++; $display("FAIL single_consecutive: got %0d want 4", got_cyc[base+4] - got_cyc[base]); end
    end
    exp_served += 5;
    tests_run++; if (served_out !== 32'(exp_served)) begin fails++; $display("FAIL single_served: got %0d want %0d", served_out, exp_served); end
  endtask

  task automatic test_round_robin();
    int base, bad, gap_bad;
    bit ok;
    int exp_who[$];
    do_reset();
    rng_restart();
    base = got_who.size();
    for (int i = 0; i < 4; i++) post(i, 2);
    tick();
    clear_req();
    wait_idle(100, ok);
    tests_run++; if (!ok) begin fails++; $display("FAIL rr_timeout: got busy=%0b want idle", busy_out); end
    exp_who = '{0, 0, 1, 1, 2, 2, 3, 3};
    count_bad(base, 8, exp_who, bad);
    tests_run++; if (bad != 0) begin fails++; $display("FAIL rr_order: got %0d bad want 0", bad); end
    gap_bad = 0;
    if (got_who.size() - base >= 8) begin
      // Within a burst words are back to back; between bursts one idle cycle.
      for (int k = 1; k < 8; k++) begin
        if (got_cyc[base+k] - got_cyc[base+k-1] != ((k % 2 == 1) ? 1 : 2)) gap_bad++;
      end
    end else gap_bad = 99;
    tests_run++; if (gap_bad != 0) begin fails++; $display("FAIL rr_bubbles: got %0d bad gaps want 0", gap_bad); end
    tests_run++; if (grant_out !== 2'd3) begin fails++; $display("FAIL rr_last_grant: got %0d want 3", grant_out); end
    exp_served += 8;
    tests_run++; if (served_out !== 32'(exp_served)) begin fails++; $display("FAIL rr_served: got %0d want %0d", served_out, exp_served); end
  endtask

  task automatic test_fairness_wrap();
    int base, bad;
    bit ok;
    int exp_who[$];
    rng_restart();
    base = got_who.size();
    // Last grant is 3: consumer 1 must beat consumer 3; zero count from 2 is dropped.
    post(1, 1); post(3, 1); post(2, 0);
    tick();
    clear_req();
    tests_run++; if (req_ready_out !== 4'b0101) begin fails++; $display("FAIL fair_pending: got %0h want 5", req_ready_out); end
    wait_idle(50, ok);
    tests_run++; if (!ok) begin fails++; $display("FAIL fair_timeout_a: got busy=%0b want idle", busy_out); end
    post(1, 1);
    tick();
    clear_req();
    wait_idle(50, ok);
    tests_run++; if (!ok) begin fails++; $display("FAIL fair_timeout_b: got busy=%0b want idle", busy_out); end
    // Last grant is 1: consumer 2 precedes consumer 0.
    post(0, 1); post(2, 1);
    tick();
    clear_req();
    wait_idle(50, ok);
    tests_run++; if (!ok) begin fails++; $display("FAIL fair_timeout_c: got busy=%0b want idle", busy_out); end
    exp_who = '{1, 3, 1, 2, 0};
    count_bad(base, 5, exp_who, bad);
    tests_run++; if (bad != 0) begin fails++; $display("FAIL fair_order: got %0d bad want 0", bad); end
    tests_run++; if (got_who.size() - base != 5) begin fails++; $display("FAIL fair_count: got %0d want 5", got_who.size() - base); end
    tests_run++; if (grant_out !== 2'd0) begin fails++; $display("FAIL fair_last_grant: got %0d want 0", grant_out); end
    exp_served += 5;
    tests_run++; if (served_out !== 32'(exp_served)) begin fails++; $display("FAIL fair_served: got %0d want %0d", served_out, exp_served); end
  endtask

  task automatic test_backpressure();
    int base, bad;
    bit rp[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    bit vp[5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    int exp_who[$];
    rng_restart();
    base = got_who.size();
    post(2, 4);
    tick();
    clear_req();
    tick();
    for (int c = 0; c < 40; c++) begin
      if (!busy_out) break;
      data_ready_in = rp[c % 4] ? 4'b1111 : 4'b1011;
      rng_valid_in  = vp[c % 5];
      #1;
      tests_run++; if (rng_ready_out !== data_ready_in[2]) begin fails++; $display("FAIL bp_rng_ready c=%0d: got %0b want %0b", c, rng_ready_out, data_ready_in[2]); end
      tests_run++; if (data_valid_out !== (rng_valid_in ? 4'b0100 : 4'b0000)) begin fails++; $display("FAIL bp_valid c=%0d: got %0h want %0h", c, data_valid_out, rng_valid_in ? 4'b0100 : 4'b0000); end
      tick();
    end
    data_ready_in = 4'hF;
    rng_valid_in  = 1'b1;
    tests_run++; if (busy_out !== 1'b0) begin fails++; $display("FAIL bp_timeout: got busy=%0b want 0", busy_out); end
    repeat (4) exp_who.push_back(2);
    count_bad(base, 4, exp_who, bad);
    tests_run++; if (bad != 0) begin fails++; $display("FAIL bp_words: got %0d bad want 0", bad); end
    tests_run++; if (got_who.size() - base != 4) begin fails++; $display("FAIL bp_count: got %0d want 4", got_who.size() - base); end
    tests_run++; if (rng_idx != 4) begin fails++; $display("FAIL bp_rng_consumed: got %0d want 4", rng_idx); end
    exp_served += 4;
    tests_run++; if (served_out !== 32'(exp_served)) begin fails++; $display("FAIL bp_served: got %0d want %0d", served_out, exp_served); end
  endtask

  task automatic test_stream_integrity();
    int base, posted, bad, cnt;
    int req_tot[4];
    int got_tot[4];
    bit done;
    do_reset();
    rng_restart();
    base = got_who.size();
    posted = 0;
    done = 1'b0;
    for (int i = 0; i < 4; i++) begin req_tot[i] = 0; got_tot[i] = 0; end
    for (int n = 0; n < 6000; n++) begin
      if (posted == 256 && !busy_out && req_ready_out == 4'hF) begin
        done = 1'b1;
        break;
      end
      data_ready_in = 4'($urandom_range(0, 15));
      rng_valid_in  = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < 4; i++) begin
        if (posted < 256 && req_ready_out[i] && $urandom_range(0, 2) == 0) begin
          cnt = int'($urandom_range(0, 12));
          if (cnt > 256 - posted) cnt = 256 - posted;
          post(i, cnt);
          posted += cnt;
          req_tot[i] += cnt;
        end
      end
      tick();
      clear_req();
    end
    data_ready_in = 4'hF;
    rng_valid_in  = 1'b1;
    tests_run++; if (!done) begin fails++; $display("FAIL int_timeout: got posted=%0d busy=%0b want idle", posted, busy_out); end
    tests_run++; if (got_who.size() - base != 256) begin fails++; $display("FAIL int_count: got %0d want 256", got_who.size() - base); end
    bad = 0;
    for (int k = 0; k < 256; k++) begin
      if (base + k >= got_who.size()) bad++;
      else begin
        if (got_data[base+k] !== seq64(k)) bad++;
        got_tot[got_who[base+k]]++;
      end
    end
    tests_run++; if (bad != 0) begin fails++; $display("FAIL int_sequence: got %0d bad want 0", bad); end
    for (int i = 0; i < 4; i++) begin
      tests_run++; if (got_tot[i] != req_tot[i]) begin fails++; $display("FAIL int_per_consumer %0d: got %0d want %0d", i, got_tot[i], req_tot[i]); end
    end
    exp_served += 256;
    tests_run++; if (served_out !== 32'(exp_served)) begin fails++; $display("FAIL int_served: got %0d want %0d", served_out, exp_served); end
    tests_run++; if (onehot_err != 0) begin fails++; $display("FAIL onehot_valid: got %0d violations want 0", onehot_err); end
  endtask

  task automatic test_reset_mid_burst();
    int base, bad;
    bit ok;
    int exp_who[$];
    do_reset();
    rng_restart();
    base = got_who.size();
    post(0, 10); post(1, 3);
    tick();
    clear_req();
    for (int n = 0; n < 50; n++) begin
      tick();
      if (got_who.size() - base >= 3) break;
    end
    tests_run++; if (got_who.size() - base != 3) begin fails++; $display("FAIL rst_mid_words: got %0d want 3", got_who.size() - base); end
    tests_run++; if (served_out !== 32'd3) begin fails++; $display("FAIL rst_mid_served_pre: got %0d want 3", served_out); end
    rst_n = 1'b0;
    #1;
    tests_run++; if (busy_out !== 1'b0) begin fails++; $display("FAIL rst_mid_busy: got %0b want 0", busy_out); end
    tests_run++; if (data_valid_out !== 4'h0) begin fails++; $display("FAIL rst_mid_valid: got %0h want 0", data_valid_out); end
    tests_run++; if (rng_ready_out !== 1'b0) begin fails++; $display("FAIL rst_mid_rng_ready: got %0b want 0", rng_ready_out); end
    tests_run++; if (served_out !== 32'd0) begin fails++; $display("FAIL rst_mid_served: got %0d want 0", served_out); end
    tests_run++; if (grant_out !== 2'd3) begin fails++; $display("FAIL rst_mid_grant: got %0d want 3", grant_out); end
    tests_run++; if (req_ready_out !== 4'hF) begin fails++; $display("FAIL rst_mid_req_ready: got %0h want f", req_ready_out); end
    tick();
    tick();
    rst_n = 1'b1;
    repeat (4) tick();
    tests_run++; if (busy_out !== 1'b0) begin fails++; $display("FAIL rst_pending_dropped: got busy=%0b want 0", busy_out); end
    exp_served = 0;
    post(0, 1);
    tick();
    clear_req();
    tick();
    tests_run++; if (busy_out !== 1'b1 || grant_out !== 2'd0) begin fails++; $display("FAIL rst_regrant: got busy=%0b grant=%0d want 1/0", busy_out, grant_out); end
    wait_idle(20, ok);
    tests_run++; if (!ok) begin fails++; $display("FAIL rst_timeout: got busy=%0b want idle", busy_out); end
    exp_who = '{0, 0, 0, 0};
    count_bad(base, 4, exp_who, bad);
    tests_run++; if (bad != 0) begin fails++; $display("FAIL rst_stream: got %0d bad want 0", bad); end
    tests_run++; if (rng_idx != 4) begin fails++; $display("FAIL rst_rng_consumed: got %0d want 4", rng_idx); end
    exp_served += 1;
    tests_run++; if (served_out !== 32'(exp_served)) begin fails++; $display("FAIL rst_served_post: got %0d want %0d", served_out, exp_served); end
  endtask

  // Watchdog: ends the run if a scenario stalls beyond any sane budget.
  initial begin
    #400000;
    $display("FAIL watchdog: got no finish want finish by 40000 cycles");
    $fatal(1, "watchdog expired");
  end

  // Test sequence and final report
  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_fairness_wrap();
    test_backpressure();
    test_stream_integrity();
    test_reset_mid_burst();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
